hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Parametrised successor to the ID-stage hazard checker. It replaces fixed ID/EXE/MEM/WB destination comparison with a per-register scoreboard.
- Each scoreboard entry holds a pending bit and a countdown of cycles until the producer's result reaches the bypass network. This supports variable-latency units (ALU, load, multi-cycle mul/div).
- Sits beside decode. Drives the pipeline stall, per-source forward-enable hints, and a saturating stall-cycle performance counter.

Parameters:
- REG_ADDR_W, 5, register address width.
- NUM_REGS, 32, number of architectural registers (2**REG_ADDR_W). Register 0 is hardwired zero.
- LAT_W, 3, width of issue latency field. Maximum latency is 2**LAT_W-1.
- CNT_W, 32, width of the stall performance counter.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- issue_valid  input  1  instruction present in decode
- rs1  input  REG_ADDR_W  source 1 address
- rs1_used  input  1  instruction reads rs1
- rs2  input  REG_ADDR_W  source 2 address
- rs2_used  input  1  instruction reads rs2
- issue_rd  input  REG_ADDR_W  destination address
- issue_rd_valid  input  1  instruction writes issue_rd
- issue_lat  input  LAT_W  cycles from issue until the result is bypassable. A value of 0 is treated as 1.
- wb_valid  input  1  register-file write this cycle
- wb_rd  input  REG_ADDR_W  register being written back
- flush  input  1  kill all in-flight producers
- stall  output  1  hold decode; do not issue
- fwd_rs1  output  1  rs1 value must come from the bypass network
- fwd_rs2  output  1  rs2 value must come from the bypass network
- stall_cnt  output  CNT_W  saturating count of stalled cycles

Behaviour:
- Clocking and reset: one clock, clk; reset is asynchronous and active-high.
  - Reset clears all pending bits and countdowns to 0.
  - Reset sets stall_cnt to 0.
  - Combinational outputs after reset: stall=0, fwd_rs1=0, fwd_rs2=0.
- Per-register state for registers 1..NUM_REGS-1: pend (1 bit) and cnt (LAT_W bits). Register 0 is never pending.
- Effective latency: L = max(issue_lat, 1).
- Combinational checks. Each check applies only when issue_valid=1; otherwise stall, fwd_rs1 and fwd_rs2 are 0.
  - RAW for rsN: when rsN_used && rsN!=0 && pend[rsN]:
    - cnt[rsN]!=0 means stall.
    - cnt[rsN]==0 means fwd_rsN=1 and no stall.
  - WAW: when issue_rd_valid && issue_rd!=0 && pend[issue_rd] && cnt[issue_rd]!=0 && cnt[issue_rd] >= L-1, stall. This prevents out-of-order or same-cycle completion to one register.
  - stall = RAW1 | RAW2 | WAW.
  - fwd_rsN is independent of stall but only meaningful when stall=0.
- Issue accept: issue_valid && !stall && !flush.
  - If issue_rd_valid && issue_rd!=0, the next edge sets pend[issue_rd]=1 and cnt[issue_rd]=L-1.
  - Consequence: a result issued at cycle T with latency L is forwardable from cycle T+L. L=1 means it is forwardable the next cycle.
- Countdown: each edge, every pending entry with cnt>0 decrements by 1. It saturates at 0.
- Writeback: wb_valid && wb_rd!=0 clears pend[wb_rd] and cnt[wb_rd] at the edge.
  - In the cycle of writeback, a consumer still sees pend=1 and cnt=0, so fwd=1 (WB bypass).
- Same-edge writeback and accept to the same register: the accept wins, so the new entry is loaded.
- Flush: synchronous. The next edge clears all pend and cnt. Any accept in the flush cycle is discarded. Flush has priority over writeback and accept.
- stall_cnt increments on each edge where stall=1. It holds at 2**CNT_W-1 and does not wrap. It is unaffected by flush.
- rd=0, or rs=0 with *_used=1, never stalls and never forwards.
- Reset asserted mid-operation clears state immediately; there is no latent stall after release.

Test Plan:
- Back-to-back ALU dependency: issue x5 with lat=1; next cycle issue with rs1=5 -> stall=0, fwd_rs1=1.
- Load-use: issue x7 with lat=2; next cycle rs2=7 -> stall=1 for exactly 1 cycle; then stall=0, fwd_rs2=1, and stall_cnt=1.
- Multi-cycle and WAW: issue x3 with lat=5; after 1 cycle issue rd=3 with lat=1 -> stall held until cnt[3]=0 (3 stall cycles), then accepted.
- Same-edge writeback and re-issue: wb_valid with wb_rd=9 and accept rd=9 lat=3 in the same cycle -> pend[9]=1 and cnt=2 afterwards; a consumer of x9 next cycle stalls.
- Flush and reset: x4 pending with cnt=3, pulse flush -> the following cycle rs1=4 gives stall=0, fwd_rs1=0. Repeat with asynchronous reset mid-cycle -> same result, and stall_cnt=0.
- Zero register and saturation: rs1=0 and rd=0 with pending history -> stall=0, fwd=0. With CNT_W=4 and 20 forced stall cycles -> stall_cnt=15.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Per-register issue scoreboard for the decode stage: RAW/WAW stall detection,
// bypass hints for variable-latency producers, and a saturating stall counter.
module hazard_scoreboard #(
  parameter int REG_ADDR_W = 5,
  parameter int NUM_REGS   = 32,
  parameter int LAT_W      = 3,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic                  rs1_used,
  input  logic [REG_ADDR_W-1:0] rs2,
  input  logic                  rs2_used,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  input  logic                  issue_rd_valid,
  input  logic [LAT_W-1:0]      issue_lat,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  flush,
  output logic                  stall,
  output logic                  fwd_rs1,
  output logic                  fwd_rs2,
  output logic [CNT_W-1:0]      stall_cnt
);

  localparam logic [LAT_W-1:0]      lat_zero = {LAT_W{1'b0}};
  localparam logic [LAT_W-1:0]      lat_one  = {{(LAT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]      cnt_max  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]      cnt_one  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [REG_ADDR_W-1:0] reg_zero = {REG_ADDR_W{1'b0}};

  logic [NUM_REGS-1:0] pend_r;
  logic [LAT_W-1:0]    cnt_r [NUM_REGS];
  logic [CNT_W-1:0]    stall_cnt_r;

  logic [LAT_W-1:0] lat_m1_s;
  logic [LAT_W-1:0] rs1_cnt_s;
  logic [LAT_W-1:0] rs2_cnt_s;
  logic [LAT_W-1:0] rd_cnt_s;
  logic             rs1_hit_s;
  logic             rs2_hit_s;
  logic             rd_hit_s;
  logic             raw1_stall_s;
  logic             raw2_stall_s;
  logic             waw_stall_s;
  logic             stall_s;
  logic             accept_s;
  logic             load_s;

  // Reload value for a new producer: latency 0 behaves like latency 1.
  always_comb begin
    lat_m1_s = lat_zero;
    if (issue_lat == lat_zero) begin
      lat_m1_s = lat_zero;
    end else begin
      lat_m1_s = issue_lat - lat_one;
    end
  end

  assign rs1_cnt_s = cnt_r[rs1];
  assign rs2_cnt_s = cnt_r[rs2];
  assign rd_cnt_s  = cnt_r[issue_rd];

  assign rs1_hit_s = issue_valid & rs1_used & (rs1 != reg_zero) & pend_r[rs1];
  assign rs2_hit_s = issue_valid & rs2_used & (rs2 != reg_zero) & pend_r[rs2];
  assign rd_hit_s  = issue_valid & issue_rd_valid & (issue_rd != reg_zero) & pend_r[issue_rd];

  // A pending source with zero countdown is sitting on the bypass network.
  assign raw1_stall_s = rs1_hit_s & (rs1_cnt_s != lat_zero);
  assign raw2_stall_s = rs2_hit_s & (rs2_cnt_s != lat_zero);
  assign waw_stall_s  = rd_hit_s & (rd_cnt_s != lat_zero) & (rd_cnt_s >= lat_m1_s);

  assign stall_s  = raw1_stall_s | raw2_stall_s | waw_stall_s;
  assign accept_s = issue_valid & ~stall_s & ~flush;
  assign load_s   = accept_s & issue_rd_valid & (issue_rd != reg_zero);

  assign stall     = stall_s;
  assign fwd_rs1   = rs1_hit_s & (rs1_cnt_s == lat_zero);
  assign fwd_rs2   = rs2_hit_s & (rs2_cnt_s == lat_zero);
  assign stall_cnt = stall_cnt_r;

  // Scoreboard update; priority is flush, then new issue, then writeback, then countdown.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_r <= {NUM_REGS{1'b0}};
      for (int i = 0; i < NUM_REGS; i++) begin
        cnt_r[i] <= lat_zero;
      end
    end else begin
      pend_r[0] <= 1'b0;
      cnt_r[0]  <= lat_zero;
      for (int i = 1; i < NUM_REGS; i++) begin
        if (flush) begin
          pend_r[i] <= 1'b0;
          cnt_r[i]  <= lat_zero;
        end else if (load_s && (issue_rd == REG_ADDR_W'(i))) begin
          pend_r[i] <= 1'b1;
          cnt_r[i]  <= lat_m1_s;
        end else if (wb_valid && (wb_rd == REG_ADDR_W'(i))) begin
          pend_r[i] <= 1'b0;
          cnt_r[i]  <= lat_zero;
        end else if (pend_r[i] && (cnt_r[i] != lat_zero)) begin
          cnt_r[i] <= cnt_r[i] - lat_one;
        end else begin
          cnt_r[i] <= cnt_r[i];
        end
      end
    end
  end

  // Saturating stall-cycle counter; flush does not touch it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (stall_s && (stall_cnt_r != cnt_max)) begin
      stall_cnt_r <= stall_cnt_r + cnt_one;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: a default instance plus a 4-bit-counter
// instance sharing stimulus (with its own reset) to exercise saturation.
module tb_hazard_scoreboard;

  logic        clk;
  logic        reset;
  logic        reset4;
  logic        issue_valid;
  logic [4:0]  rs1;
  logic        rs1_used;
  logic [4:0]  rs2;
  logic        rs2_used;
  logic [4:0]  issue_rd;
  logic        issue_rd_valid;
  logic [2:0]  issue_lat;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        flush;
  logic        stall;
  logic        fwd_rs1;
  logic        fwd_rs2;
  logic [31:0] stall_cnt;
  logic        stall4;
  logic        fwd4_rs1;
  logic        fwd4_rs2;
  logic [3:0]  stall_cnt4;

  int n_checks;
  int n_pass;
  int n_stalls;

  hazard_scoreboard dut (
    .clk(clk), .reset(reset), .issue_valid(issue_valid),
    .rs1(rs1), .rs1_used(rs1_used), .rs2(rs2), .rs2_used(rs2_used),
    .issue_rd(issue_rd), .issue_rd_valid(issue_rd_valid), .issue_lat(issue_lat),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
    .stall(stall), .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2), .stall_cnt(stall_cnt)
  );

  hazard_scoreboard #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset4), .issue_valid(issue_valid),
    .rs1(rs1), .rs1_used(rs1_used), .rs2(rs2), .rs2_used(rs2_used),
    .issue_rd(issue_rd), .issue_rd_valid(issue_rd_valid), .issue_lat(issue_lat),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
    .stall(stall4), .fwd_rs1(fwd4_rs1), .fwd_rs2(fwd4_rs2), .stall_cnt(stall_cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [4:0] r1, input logic u1,
                       input logic [4:0] r2, input logic u2,
                       input logic [4:0] rd, input logic rdv, input logic [2:0] lat);
    issue_valid    = iv;
    rs1            = r1;
    rs1_used       = u1;
    rs2            = r2;
    rs2_used       = u2;
    issue_rd       = rd;
    issue_rd_valid = rdv;
    issue_lat      = lat;
    wb_valid       = 1'b0;
    wb_rd          = 5'd0;
    flush          = 1'b0;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 3'd0);
  endtask

  task automatic wb(input logic [4:0] r);
    idle();
    wb_valid = 1'b1;
    wb_rd    = r;
    #1;
    tick();
    wb_valid = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b1;
    reset4   = 1'b1;
    idle();
    tick();
    tick();
    reset  = 1'b0;
    reset4 = 1'b0;

    // Reset state
    drive(1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 5'd7, 1'b1, 3'd1);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_fwd1", {31'd0, fwd_rs1}, 32'd0);
    chk("rst_fwd2", {31'd0, fwd_rs2}, 32'd0);
    chk("rst_cnt", stall_cnt, 32'd0);
    idle();

    // Back-to-back ALU dependency
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 3'd1);
    tick();
    drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 3'd0);
    chk("alu_stall", {31'd0, stall}, 32'd0);
    chk("alu_fwd1", {31'd0, fwd_rs1}, 32'd1);
    tick();
    wb_valid = 1'b1;
    wb_rd    = 5'd5;
    #1;
    chk("wb_bypass_fwd1", {31'd0, fwd_rs1}, 32'd1);
    tick();
    wb_valid = 1'b0;
    #1;
    chk("after_wb_fwd1", {31'd0, fwd_rs1}, 32'd0);
    idle();

    // Load-use: one stall cycle then forward
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 3'd2);
    tick();
    drive(1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 3'd0);
    chk("lu_stall", {31'd0, stall}, 32'd1);
    chk("lu_fwd2_during", {31'd0, fwd_rs2}, 32'd0);
    tick();
    chk("lu_stall_after", {31'd0, stall}, 32'd0);
    chk("lu_fwd2", {31'd0, fwd_rs2}, 32'd1);
    chk("lu_cnt", stall_cnt, 32'd1);
    chk("lu_cnt4", {28'd0, stall_cnt4}, 32'd1);
    tick();
    wb(5'd7);

    // WAW behind a 5-cycle producer
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 3'd5);
    tick();
    idle();
    tick();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 3'd1);
    n_stalls = 0;
    for (int k = 0; k < 10; k++) begin
      if (!stall) break;
      n_stalls++;
      tick();
    end
    chk("waw_stalls", n_stalls, 32'd3);
    chk("waw_cnt", stall_cnt, 32'd4);
    tick();
    drive(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 3'd0);
    chk("waw_new_fwd1", {31'd0, fwd_rs1}, 32'd1);
    chk("waw_new_stall", {31'd0, stall}, 32'd0);
    wb(5'd3);

    // Same-edge writeback and re-issue of x9
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 3'd1);
    tick();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 3'd3);
    wb_valid = 1'b1;
    wb_rd    = 5'd9;
    #1;
    chk("same_edge_stall", {31'd0, stall}, 32'd0);
    tick();
    drive(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 3'd0);
    chk("same_edge_consumer", {31'd0, stall}, 32'd1);
    idle();
    chk("idle_no_stall", {31'd0, stall}, 32'd0);
    tick();
    tick();
    drive(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 3'd0);
    chk("x9_ready_stall", {31'd0, stall}, 32'd0);
    chk("x9_ready_fwd1", {31'd0, fwd_rs1}, 32'd1);
    wb(5'd9);

    // Flush kills producers and the accept in the same cycle
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 3'd4);
    tick();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 3'd1);
    flush = 1'b1;
    #1;
    tick();
    drive(1'b1, 5'd4, 1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 3'd0);
    chk("flush_stall", {31'd0, stall}, 32'd0);
    chk("flush_fwd1", {31'd0, fwd_rs1}, 32'd0);
    chk("flush_fwd2", {31'd0, fwd_rs2}, 32'd0);
    chk("flush_cnt", stall_cnt, 32'd4);
    idle();

    // Asynchronous reset mid-cycle
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 3'd4);
    tick();
    drive(1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 3'd0);
    chk("pre_reset_stall", {31'd0, stall}, 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("async_rst_stall", {31'd0, stall}, 32'd0);
    chk("async_rst_cnt", stall_cnt, 32'd0);
    #1 reset = 1'b0;
    tick();
    chk("post_rst_stall", {31'd0, stall}, 32'd0);
    chk("post_rst_fwd1", {31'd0, fwd_rs1}, 32'd0);
    chk("post_rst_cnt", stall_cnt, 32'd0);
    idle();

    // Zero register never stalls or forwards
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 3'd5);
    tick();
    drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 3'd7);
    chk("x0_stall", {31'd0, stall}, 32'd0);
    chk("x0_fwd1", {31'd0, fwd_rs1}, 32'd0);
    chk("x0_fwd2", {31'd0, fwd_rs2}, 32'd0);
    tick();

    // 20 forced stall cycles: producer lat=7 then 5 stalled consumer cycles, x4
    n_stalls = 0;
    for (int r = 0; r < 4; r++) begin
      drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd12, 1'b1, 3'd7);
      tick();
      drive(1'b1, 5'd12, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 3'd0);
      for (int k = 0; k < 5; k++) begin
        if (stall) n_stalls++;
        tick();
      end
    end
    idle();
    chk("sat_stalls_seen", n_stalls, 32'd20);
    chk("sat_cnt32", stall_cnt, 32'd20);
    chk("sat_cnt4", {28'd0, stall_cnt4}, 32'd15);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
